rand_whiten: RTL and testbench

Conditioning stage directly downstream of the raw entropy collectors (ADC-bit and clock-jitter samplers). It accepts raw `ws`-bit words and removes bias with a von Neumann pair extractor. It packs the surviving bits into full words and mixes each one with a Galois LFSR. Results are buffered in a small FIFO and handed to consumers over a valid/ready handshake. An optional repetition-count health test flags a stuck source.

---
 rtl/rand_pkg.sv | 20 ++
 rtl/rand_if.sv | 34 +++
 rtl/rand_fifo.sv | 55 +++++
 rtl/rand_whiten.sv | 167 ++++++++++++++++
 tb/tb_rand_whiten.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/rand_pkg.sv
// rand_pkg
//   Shared constants and types for the rand_whiten conditioning stage:
//   default word width, FIFO depth, Galois LFSR feedback mask and seed,
//   the repetition-count limit, and the extractor state encoding.
//   No ports; imported by the interface, the FIFO and the top.
package rand_pkg;

  localparam int          WS_DEFAULT        = 16;
  localparam int          DEPTH_DEFAULT     = 4;
  localparam logic [15:0] POLY_DEFAULT      = 16'hB400;
  localparam logic [15:0] SEED_DEFAULT      = 16'hACE1;
  localparam int          REP_LIMIT_DEFAULT = 4;

  // IDLE waits for a raw word, PAIR walks its bit pairs one per edge
  typedef enum logic {
    IDLE = 1'b0,
    PAIR = 1'b1
  } state_t;

endpackage

// File: rtl/rand_if.sv
// rand_if
//   Bundles the raw-input handshake, the conditioned-output handshake and
//   the status flags of rand_whiten.
//   iRaw/iRawValid/oRawReady : raw word from the entropy collector
//   oOut/oValid/iReady       : conditioned word to the consumer (FIFO head)
//   oOverflow                : one-cycle pulse when a finished word is dropped
//   oFault                   : sticky repetition-count health failure
//   Modport slave is the block side, master is the collector/consumer side.
interface rand_if
  import rand_pkg::*;
#(
  parameter int ws = WS_DEFAULT
);

  logic [ws-1:0] iRaw;
  logic          iRawValid;
  logic          oRawReady;
  logic [ws-1:0] oOut;
  logic          oValid;
  logic          iReady;
  logic          oOverflow;
  logic          oFault;

  modport master (
    output iRaw, iRawValid, iReady,
    input  oRawReady, oOut, oValid, oOverflow, oFault
  );

  modport slave (
    input  iRaw, iRawValid, iReady,
    output oRawReady, oOut, oValid, oOverflow, oFault
  );

endinterface

// File: rtl/rand_fifo.sv
// rand_fifo
//   Small circular-buffer FIFO for conditioned words. The pointers carry
//   one extra wrap bit so full and empty can be told apart.
//   iCLK/iRST_N : falling-edge clock, asynchronous active-low reset
//   iPushData/iPush : word to write and write request
//   iPop        : read request (ignored when empty)
//   oHead       : word at the head, oEmpty/oFull : occupancy flags
//   A push while full still succeeds when a pop happens on the same edge.
module rand_fifo
  import rand_pkg::*;
#(
  parameter int ws    = WS_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic          iCLK,
  input  logic          iRST_N,
  input  logic [ws-1:0] iPushData,
  input  logic          iPush,
  input  logic          iPop,
  output logic [ws-1:0] oHead,
  output logic          oEmpty,
  output logic          oFull
);

  localparam int AW = $clog2(DEPTH);

  logic [ws-1:0] r_mem [DEPTH];
  logic [AW:0]   r_wrPtr;
  logic [AW:0]   r_rdPtr;
  logic          w_doPush;
  logic          w_doPop;

  assign oEmpty   = (r_wrPtr == r_rdPtr);
  assign oFull    = (r_wrPtr[AW] != r_rdPtr[AW]) &&
                    (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
  assign w_doPop  = iPop && !oEmpty;
  assign w_doPush = iPush && (!oFull || w_doPop);
  assign oHead    = r_mem[r_rdPtr[AW-1:0]];

  // Storage is cleared on reset so the head reads zero out of reset
  always_ff @(negedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_doPush) begin
        r_mem[r_wrPtr[AW-1:0]] <= iPushData;
        r_wrPtr                <= r_wrPtr + 1'b1;
      end
      if (w_doPop) r_rdPtr <= r_rdPtr + 1'b1;
    end
  end

endmodule

// File: rtl/rand_whiten.sv
// rand_whiten
//   Entropy conditioning stage: a von Neumann pair extractor removes bias
//   from raw words, surviving bits are packed LSB first into full words,
//   each full word is XOR-mixed with a Galois LFSR and queued in rand_fifo.
//   iCLK   : clock, all state changes on the falling edge
//   iRST_N : asynchronous active-low reset
//   bus    : rand_if slave (raw handshake, output handshake, flags)
//   Optional repetition-count health test: define RAND_HEALTH_EN.
module rand_whiten
  import rand_pkg::*;
#(
  parameter int            ws    = WS_DEFAULT,
  parameter int            DEPTH = DEPTH_DEFAULT,
  parameter logic [ws-1:0] POLY  = POLY_DEFAULT,
  parameter logic [ws-1:0] SEED  = SEED_DEFAULT
`ifdef RAND_HEALTH_EN
  ,
  parameter int            REP_LIMIT = REP_LIMIT_DEFAULT
`endif
) (
  input logic   iCLK,
  input logic   iRST_N,
  rand_if.slave bus
);

  localparam int            PW        = (ws / 2 > 1) ? $clog2(ws / 2) : 1;
  localparam int            CW        = $clog2(ws);
  localparam logic [PW-1:0] LAST_PAIR = PW'(ws / 2 - 1);
  localparam logic [CW-1:0] LAST_BIT  = CW'(ws - 1);

  state_t        r_state;
  state_t        w_nextState;
  logic [ws-1:0] r_word;
  logic [PW-1:0] r_pair;
  logic [ws-2:0] r_acc;
  logic [CW-1:0] r_cnt;
  logic [ws-1:0] r_lfsr;
  logic          r_overflow;

  logic          w_bitA;
  logic          w_bitB;
  logic          w_emit;
  logic          w_complete;
  logic [ws-1:0] w_pushWord;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_pushOk;
  logic          w_drop;
  logic          w_rawAccept;
  logic          w_fault;

  assign w_bitA      = r_word[{r_pair, 1'b0}];
  assign w_bitB      = r_word[{r_pair, 1'b1}];
  assign w_emit      = (r_state == PAIR) && (w_bitA != w_bitB);
  // The finishing bit goes straight into the pushed word, never into r_acc
  assign w_complete  = w_emit && (r_cnt == LAST_BIT);
  assign w_pushWord  = {w_bitA, r_acc} ^ r_lfsr;
  assign w_pop       = !w_empty && bus.iReady;
  assign w_pushOk    = w_complete && (!w_full || w_pop);
  assign w_drop      = w_complete && !w_pushOk;
  assign w_rawAccept = bus.oRawReady && bus.iRawValid;

  assign bus.oValid    = !w_empty;
  assign bus.oOverflow = r_overflow;
  assign bus.oFault    = w_fault;

  always_ff @(negedge iCLK or negedge iRST_N) begin
    if (!iRST_N) r_state <= IDLE;
    else         r_state <= w_nextState;
  end

  // A fault blocks new raw words but lets an in-flight word finish its pairs
  always_comb begin
    w_nextState   = r_state;
    bus.oRawReady = 1'b0;
    case (r_state)
      IDLE: begin
        bus.oRawReady = !w_fault;
        if (w_rawAccept) w_nextState = PAIR;
      end
      PAIR: begin
        if (r_pair == LAST_PAIR) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Accumulator and bit count survive across raw words; only reset clears
  // them. The LFSR advances only when a finished word actually enters the FIFO.
  always_ff @(negedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_word     <= '0;
      r_pair     <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_lfsr     <= SEED;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= w_drop;
      if (w_rawAccept) begin
        r_word <= bus.iRaw;
        r_pair <= '0;
      end else if (r_state == PAIR) begin
        r_pair <= r_pair + 1'b1;
      end
      if (w_emit) begin
        if (w_complete) begin
          r_cnt <= '0;
        end else begin
          r_acc[r_cnt] <= w_bitA;
          r_cnt        <= r_cnt + 1'b1;
        end
      end
      if (w_pushOk) r_lfsr <= (r_lfsr >> 1) ^ (r_lfsr[0] ? POLY : '0);
    end
  end

`ifdef RAND_HEALTH_EN
  localparam int RW = $clog2(REP_LIMIT + 1);

  logic [ws-1:0] r_prevRaw;
  logic [RW-1:0] r_rep;
  logic          r_fault;
  logic [RW-1:0] w_repNext;

  // r_rep is zero only before the first accepted word, so it doubles as
  // the "have a previous word" flag
  always_comb begin
    w_repNext = RW'(1);
    if ((r_rep != '0) && (bus.iRaw == r_prevRaw)) begin
      w_repNext = (r_rep == RW'(REP_LIMIT)) ? r_rep : r_rep + 1'b1;
    end
  end

  always_ff @(negedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_prevRaw <= '0;
      r_rep     <= '0;
      r_fault   <= 1'b0;
    end else if (w_rawAccept) begin
      r_prevRaw <= bus.iRaw;
      r_rep     <= w_repNext;
      if (w_repNext == RW'(REP_LIMIT)) r_fault <= 1'b1;
    end
  end

  assign w_fault = r_fault;
`else
  assign w_fault = 1'b0;
`endif

  rand_fifo #(
    .ws    (ws),
    .DEPTH (DEPTH)
  ) uFifo (
    .iCLK      (iCLK),
    .iRST_N    (iRST_N),
    .iPushData (w_pushWord),
    .iPush     (w_pushOk),
    .iPop      (w_pop),
    .oHead     (bus.oOut),
    .oEmpty    (w_empty),
    .oFull     (w_full)
  );

endmodule

// File: tb/tb_rand_whiten.sv
// tb_rand_whiten
//   Directed bench for rand_whiten. A word-level model of the extractor,
//   packer and LFSR pushes expected conditioned words into a queue as raw
//   words are offered; a monitor pops and compares on every output handshake.
module tb_rand_whiten;

  localparam int DEPTH = 4;

  logic clk = 1'b1;
  logic rstN;
  int   checks = 0;
  int   errors = 0;

  rand_if #(.ws(16)) bus ();

  rand_whiten dut (
    .iCLK   (clk),
    .iRST_N (rstN),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Model state
  logic [15:0] mAcc;
  int          mCnt;
  logic [15:0] mLfsr;
  logic [15:0] q[$];
  int          expOverflow;
  int          seenOverflow;
  bit          expFault;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic resetModel();
    mAcc         = '0;
    mCnt         = 0;
    mLfsr        = 16'hACE1;
    q.delete();
    expOverflow  = 0;
    seenOverflow = 0;
    expFault     = 1'b0;
  endtask

  // Von Neumann extraction, LSB-first packing, Galois mixing, FIFO room
  task automatic modelWord(input logic [15:0] w);
    logic a, b;
    logic [15:0] word;
    for (int k = 0; k < 8; k++) begin
      a = w[2*k];
      b = w[2*k+1];
      if (a != b) begin
        if (mCnt == 15) begin
          word = {a, mAcc[14:0]} ^ mLfsr;
          mCnt = 0;
          if (q.size() < DEPTH) begin
            q.push_back(word);
            mLfsr = {1'b0, mLfsr[15:1]} ^ (mLfsr[0] ? 16'hB400 : 16'h0000);
          end else begin
            expOverflow++;
          end
        end else begin
          mAcc[mCnt] = a;
          mCnt++;
        end
      end
    end
  endtask

  task automatic resetDut();
    @(negedge clk);
    #1 rstN = 1'b0;
    resetModel();
    #3;
    @(negedge clk);
    #1 rstN = 1'b1;
  endtask

  // Offers one raw word, then checks the busy window and ready return
  task automatic applyStimulus(input logic [15:0] w);
    int n = 0;
    while (bus.oRawReady !== 1'b1 && n < 40) begin
      @(posedge clk);
      n++;
    end
    checkOutput("rawReady before offer", 32'(bus.oRawReady), 32'd1);
    bus.iRaw      = w;
    bus.iRawValid = 1'b1;
    @(negedge clk);
    #1;
    bus.iRawValid = 1'b0;
    bus.iRaw      = 16'($urandom);
    modelWord(w);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      checkOutput("rawReady busy", 32'(bus.oRawReady), 32'd0);
      if (i == 0) checkOutput("fault after accept", 32'(bus.oFault), 32'(expFault));
      @(negedge clk);
    end
    @(posedge clk);
    checkOutput("rawReady after pairs", 32'(bus.oRawReady), 32'(!expFault));
  endtask

  // Scoreboard monitor, sampling on the edge opposite the DUT's
  always @(posedge clk) begin
    if (rstN === 1'b1) begin
      if (bus.oOverflow === 1'b1) seenOverflow++;
      if (bus.oValid === 1'b1 && bus.iReady === 1'b1) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $error("[TB] FAIL unexpected word: observed %0h expected none", bus.oOut);
        end else begin
          checkOutput("scoreboard word", 32'(bus.oOut), 32'(q.pop_front()));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: observed no finish expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int n;
    resetModel();
    rstN          = 1'b0;
    bus.iRaw      = '0;
    bus.iRawValid = 1'b0;
    bus.iReady    = 1'b1;

    // 1. Reset with random inputs
    $display("[TB] reset state");
    for (int i = 0; i < 3; i++) begin
      bus.iRaw      = 16'($urandom);
      bus.iRawValid = 1'($urandom);
      bus.iReady    = 1'($urandom);
      #7;
    end
    checkOutput("reset oRawReady", 32'(bus.oRawReady), 32'd1);
    checkOutput("reset oValid",    32'(bus.oValid),    32'd0);
    checkOutput("reset oOut",      32'(bus.oOut),      32'd0);
    checkOutput("reset oOverflow", 32'(bus.oOverflow), 32'd0);
    checkOutput("reset oFault",    32'(bus.oFault),    32'd0);
    bus.iRawValid = 1'b0;
    bus.iReady    = 1'b1;
    @(negedge clk);
    #1 rstN = 1'b1;

    // 2. Two 5555 words -> 531E, then the advanced LFSR (E270) mixes the next
    $display("[TB] 5555 pairs");
    applyStimulus(16'h5555);
    checkOutput("no word after 8 bits", 32'(bus.oValid), 32'd0);
    applyStimulus(16'h5555);
    checkOutput("first word valid", 32'(bus.oValid), 32'd1);
    checkOutput("first word value", 32'(bus.oOut), 32'h531E);
    applyStimulus(16'h5555);
    applyStimulus(16'h5555);
    checkOutput("second word value", 32'(bus.oOut), 32'h1D8F);
    repeat (2) @(posedge clk);
    checkOutput("t2 drained", 32'(q.size()), 32'd0);

    // 3. All-equal pairs emit nothing and leave the bit count at zero
    $display("[TB] equal pairs");
    resetDut();
    applyStimulus(16'h0000);
    applyStimulus(16'hFFFF);
    checkOutput("equal pairs no output", 32'(bus.oValid), 32'd0);
    applyStimulus(16'h5555);
    applyStimulus(16'h5555);
    checkOutput("count held at zero", 32'(bus.oOut), 32'h531E);

    // 4. 5555 then AAAA -> 00FF ^ ACE1
    $display("[TB] mixed pairs");
    resetDut();
    applyStimulus(16'h5555);
    applyStimulus(16'hAAAA);
    checkOutput("mixed word value", 32'(bus.oOut), 32'hAC1E);
    repeat (2) @(posedge clk);

    // 5. Overflow with the consumer stalled
    $display("[TB] overflow");
    resetDut();
    bus.iReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(16'h5555);
      applyStimulus(16'hAAAA);
    end
    @(negedge clk);
    checkOutput("overflow pulses", 32'(seenOverflow), 32'(expOverflow));
    checkOutput("overflow one drop", 32'(expOverflow), 32'd1);
    @(posedge clk);
    checkOutput("overflow cleared", 32'(bus.oOverflow), 32'd0);
    checkOutput("full head valid", 32'(bus.oValid), 32'd1);
    checkOutput("full head value", 32'(bus.oOut), 32'hAC1E);
    checkOutput("fifo model count", 32'(q.size()), 32'd4);
    @(negedge clk);
    #1 bus.iReady = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    #1;
    checkOutput("drain complete", 32'(q.size()), 32'd0);
    checkOutput("drained oValid", 32'(bus.oValid), 32'd0);

    // 6. Repetition-count health test
    $display("[TB] health");
    resetDut();
`ifdef RAND_HEALTH_EN
    applyStimulus(16'h1234);
    applyStimulus(16'h1234);
    applyStimulus(16'h1234);
    expFault = 1'b1;
    applyStimulus(16'h1234);
    bus.iRaw      = 16'h5555;
    bus.iRawValid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      checkOutput("fault blocks raw", 32'(bus.oRawReady), 32'd0);
    end
    bus.iRawValid = 1'b0;
    checkOutput("fault sticky", 32'(bus.oFault), 32'd1);
    checkOutput("fault no words", 32'(bus.oValid), 32'd0);

    // Second run: reset lands while the 4th word is still in PAIR
    resetDut();
    applyStimulus(16'h1234);
    applyStimulus(16'h1234);
    applyStimulus(16'h1234);
    bus.iRaw      = 16'h1234;
    bus.iRawValid = 1'b1;
    @(negedge clk);
    #1 bus.iRawValid = 1'b0;
    @(posedge clk);
    checkOutput("fault on 4th", 32'(bus.oFault), 32'd1);
    @(negedge clk);
    #2 rstN = 1'b0;
    #1;
    checkOutput("async reset clears fault", 32'(bus.oFault), 32'd0);
    checkOutput("async reset to idle", 32'(bus.oRawReady), 32'd1);
    resetModel();
    @(negedge clk);
    #1 rstN = 1'b1;
    applyStimulus(16'h5555);
    applyStimulus(16'h5555);
    checkOutput("after reset word", 32'(bus.oOut), 32'h531E);
`else
    for (int i = 0; i < 4; i++) applyStimulus(16'h1234);
    applyStimulus(16'h1234);
    checkOutput("fault tied low", 32'(bus.oFault), 32'd0);
`endif
    repeat (3) @(posedge clk);
    checkOutput("final queue empty", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
